// File: rtl/knn_topk_voter.sv
// K-nearest-neighbour voter: keeps the K smallest (distance, label) pairs of a query
// in a sorted list, then majority-votes their labels (ties go to the lowest class).
module knn_topk_voter #(
    parameter int K           = 3,
    parameter int DIST_W      = 18,
    parameter int LABEL_W     = 2,
    parameter int NUM_CLASSES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DIST_W-1:0]  in_dist_i,
    input  logic [LABEL_W-1:0] in_label_i,
    input  logic               in_last_i,
    output logic               busy_o,
    output logic               result_valid_o,
    output logic [LABEL_W-1:0] result_label_o,
    output logic [DIST_W-1:0]  nn_dist_o
);

    localparam int CNT_W = $clog2(K + 1);
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VOTE, S_RESOLVE} state_t;

    state_t               state_q, state_d;
    logic [DIST_W-1:0]    dist_q  [K];
    logic [DIST_W-1:0]    dist_d  [K];
    logic [LABEL_W-1:0]   label_q [K];
    logic [LABEL_W-1:0]   label_d [K];
    logic [K-1:0]         valid_q, valid_d;
    logic [CNT_W-1:0]     cnt_q   [NUM_CLASSES];
    logic [CNT_W-1:0]     cnt_d   [NUM_CLASSES];
    logic [IDX_W-1:0]     vidx_q, vidx_d;
    logic [LABEL_W-1:0]   res_label_q, res_label_d;
    logic                 res_valid_q, res_valid_d;

    // Insertion network: lt is monotone along the list, so the sample lands at the
    // first set bit and everything from there down moves one slot.
    logic [K-1:0]         lt;
    logic [DIST_W-1:0]    ins_dist  [K];
    logic [LABEL_W-1:0]   ins_label [K];
    logic [K-1:0]         ins_valid;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_ins
            assign lt[gi] = !valid_q[gi] || (in_dist_i < dist_q[gi]);
            if (gi == 0) begin : g_head
                assign ins_dist[gi]  = lt[gi] ? in_dist_i  : dist_q[gi];
                assign ins_label[gi] = lt[gi] ? in_label_i : label_q[gi];
                assign ins_valid[gi] = lt[gi] ? 1'b1       : valid_q[gi];
            end else begin : g_tail
                assign ins_dist[gi]  = lt[gi-1] ? dist_q[gi-1]  : (lt[gi] ? in_dist_i  : dist_q[gi]);
                assign ins_label[gi] = lt[gi-1] ? label_q[gi-1] : (lt[gi] ? in_label_i : label_q[gi]);
                assign ins_valid[gi] = lt[gi-1] ? valid_q[gi-1] : (lt[gi] ? 1'b1       : valid_q[gi]);
            end
        end
    endgenerate

    logic [LABEL_W-1:0] best_label;
    logic [CNT_W-1:0]   best_cnt;

    always_comb begin
        best_label = '0;
        best_cnt   = cnt_q[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (cnt_q[c] > best_cnt) begin
                best_cnt   = cnt_q[c];
                best_label = LABEL_W'(c);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        dist_d      = dist_q;
        label_d     = label_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        vidx_d      = vidx_q;
        res_label_d = res_label_q;
        res_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_COLLECT;
                    valid_d = '0;
                    vidx_d  = '0;
                    for (int i = 0; i < K; i++) dist_d[i] = '1;
                    for (int c = 0; c < NUM_CLASSES; c++) cnt_d[c] = '0;
                end
            end
            S_COLLECT: begin
                if (in_valid_i) begin
                    dist_d  = ins_dist;
                    label_d = ins_label;
                    valid_d = ins_valid;
                    if (in_last_i) begin
                        state_d = S_VOTE;
                        vidx_d  = '0;
                    end
                end
            end
            S_VOTE: begin
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    if (valid_q[vidx_q] && (label_q[vidx_q] == LABEL_W'(c)))
                        cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
                if (vidx_q == IDX_W'(K - 1)) state_d = S_RESOLVE;
                else                         vidx_d  = vidx_q + IDX_W'(1);
            end
            S_RESOLVE: begin
                res_label_d = best_label;
                res_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            vidx_q      <= '0;
            res_label_q <= '0;
            res_valid_q <= 1'b0;
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= '1;
                label_q[i] <= '0;
            end
            for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
        end else begin
            state_q     <= state_d;
            dist_q      <= dist_d;
            label_q     <= label_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            vidx_q      <= vidx_d;
            res_label_q <= res_label_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign in_ready_o     = (state_q == S_COLLECT);
    assign busy_o         = (state_q != S_IDLE);
    assign result_valid_o = res_valid_q;
    assign result_label_o = res_label_q;
    assign nn_dist_o      = dist_q[0];

endmodule
